// File: rtl/uid_frame_pkg.sv
// Shared constants and types for the UID frame parser and the downstream
// reply logic: state encoding, framing bytes, command codes, error codes
// and the legal-length check.
package uid_frame_pkg;

  localparam logic [7:0] SOF           = 8'h55;
  localparam logic [7:0] CMD_CHECK_UID = 8'hA1;
  localparam logic [7:0] CMD_ADD_UID   = 8'hB2;

  localparam int unsigned ERR_W = 3;
  localparam logic [ERR_W-1:0] ERR_BAD_CMD  = 3'd1;
  localparam logic [ERR_W-1:0] ERR_BAD_LEN  = 3'd2;
  localparam logic [ERR_W-1:0] ERR_CHECKSUM = 3'd3;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT  = 3'd4;
  localparam logic [ERR_W-1:0] ERR_OVERRUN  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_UID,
    ST_CHK,
    ST_HOLD
  } state_e;

  // LEN is legal when it is a supported UID size that fits the output bus.
  function automatic logic len_legal(input logic [7:0] len, input int unsigned max_bytes);
    return ((len == 8'd4) || (len == 8'd7) || (len == 8'd10)) && (32'(len) <= max_bytes);
  endfunction

endpackage

// File: rtl/uid_frame_parser_if.sv
// Bus bundle of the UID frame parser.
//   rx_data/rx_ready         : byte stream from the UART receiver
//   cmd_out/uid_out/uid_len  : validated frame payload
//   frame_valid/frame_ready  : payload handshake
//   err_pulse/err_code       : one-cycle rejection report
// master: the surrounding logic (byte source + frame consumer)
// slave : the parser
interface uid_frame_parser_if #(
  parameter int unsigned MAX_UID_BYTES = 10
) ();

  logic [7:0]                 rx_data;
  logic                       rx_ready;
  logic [7:0]                 cmd_out;
  logic [8*MAX_UID_BYTES-1:0] uid_out;
  logic [3:0]                 uid_len;
  logic                       frame_valid;
  logic                       frame_ready;
  logic                       err_pulse;
  logic [2:0]                 err_code;

  modport master (
    output rx_data, rx_ready, frame_ready,
    input  cmd_out, uid_out, uid_len, frame_valid, err_pulse, err_code
  );

  modport slave (
    input  rx_data, rx_ready, frame_ready,
    output cmd_out, uid_out, uid_len, frame_valid, err_pulse, err_code
  );

endinterface

// File: rtl/uid_frame_parser.sv
// UID frame parser: assembles SOF, CMD, LEN, UID bytes and XOR checksum from
// the UART byte stream, presents validated frames over a valid/ready
// handshake and reports rejected frames/bytes with a one-cycle error pulse.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uid_frame_parser_if.slave (rx byte stream, frame payload,
//                handshake, error report)
// Build option: define UID_FRAME_TIMEOUT_EN to build the inter-byte timeout
// (error code 4); without it a stalled partial frame waits indefinitely.
module uid_frame_parser
  import uid_frame_pkg::*;
#(
  parameter int unsigned MAX_UID_BYTES  = 10,
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter logic [7:0]  SOF_BYTE       = SOF
) (
  input logic              clk,
  input logic              rst_n,
  uid_frame_parser_if.slave bus
);

  localparam int unsigned UID_W = 8 * MAX_UID_BYTES;
  localparam int unsigned IDX_W = (MAX_UID_BYTES > 1) ? $clog2(MAX_UID_BYTES) : 1;

  state_e                 state_q, state_d;
  logic [7:0]             chk_q, chk_d;
  logic [7:0]             cmd_sh_q, cmd_sh_d;
  logic [3:0]             len_sh_q, len_sh_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             uid_sh_q [MAX_UID_BYTES];
  logic [7:0]             uid_sh_d [MAX_UID_BYTES];

  logic [7:0]             cmd_q, cmd_d;
  logic [UID_W-1:0]       uid_q, uid_d;
  logic [3:0]             len_q, len_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [ERR_W-1:0]       code_q, code_d;

  logic                   sof_c;
  logic                   handshake_c;
  logic                   tmo_hit_c;

  assign sof_c       = bus.rx_ready && (bus.rx_data == SOF_BYTE);
  assign handshake_c = valid_q && bus.frame_ready;

`ifdef UID_FRAME_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_active_c;

  // Inter-byte timeout: runs only while a frame is partially received.
  always_comb begin
    tmo_d        = '0;
    tmo_hit_c    = 1'b0;
    tmo_active_c = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                   (state_q == ST_UID) || (state_q == ST_CHK);
    if (tmo_active_c && !bus.rx_ready) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        tmo_hit_c = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign tmo_hit_c          = 1'b0;
  assign unused_timeout_cfg = ^{32'(TIMEOUT_CYCLES), ERR_TIMEOUT};
`endif

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d  = state_q;
    chk_d    = chk_q;
    cmd_sh_d = cmd_sh_q;
    len_sh_d = len_sh_q;
    idx_d    = idx_q;
    uid_sh_d = uid_sh_q;
    cmd_d    = cmd_q;
    uid_d    = uid_q;
    len_d    = len_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    code_d   = code_q;

    case (state_q)
      ST_IDLE: begin
        if (sof_c) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (bus.rx_ready) begin
          if ((bus.rx_data == CMD_CHECK_UID) || (bus.rx_data == CMD_ADD_UID)) begin
            cmd_sh_d = bus.rx_data;
            chk_d    = bus.rx_data;
            state_d  = ST_LEN;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_BAD_CMD;
            state_d = ST_IDLE;
          end
        end
      end
      ST_LEN: begin
        if (bus.rx_ready) begin
          if (len_legal(bus.rx_data, MAX_UID_BYTES)) begin
            len_sh_d = 4'(bus.rx_data);
            chk_d    = chk_q ^ bus.rx_data;
            idx_d    = '0;
            state_d  = ST_UID;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_BAD_LEN;
            state_d = ST_IDLE;
          end
        end
      end
      ST_UID: begin
        if (bus.rx_ready) begin
          uid_sh_d[idx_q] = bus.rx_data;
          chk_d           = chk_q ^ bus.rx_data;
          if (idx_q == IDX_W'(len_sh_q - 4'd1)) begin
            state_d = ST_CHK;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_CHK: begin
        if (bus.rx_ready) begin
          if (bus.rx_data == chk_q) begin
            cmd_d = cmd_sh_q;
            len_d = len_sh_q;
            // First received byte lands in the MSBs; unused bytes were cleared.
            for (int unsigned i = 0; i < MAX_UID_BYTES; i++) begin
              uid_d[8*(MAX_UID_BYTES-1-i) +: 8] = uid_sh_q[i];
            end
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CHECKSUM;
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        // A byte arriving with the handshake is handled as in IDLE.
        if (handshake_c) begin
          valid_d = 1'b0;
          state_d = sof_c ? ST_CMD : ST_IDLE;
        end else if (bus.rx_ready) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Timeout only fires on cycles without rx_ready, so it never races a byte.
    if (tmo_hit_c) begin
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      state_d = ST_IDLE;
    end

    // Fresh frame: clear the UID shadow and the checksum.
    if ((state_d == ST_CMD) && (state_q != ST_CMD)) begin
      uid_sh_d = '{default: '0};
      chk_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      chk_q    <= '0;
      cmd_sh_q <= '0;
      len_sh_q <= '0;
      idx_q    <= '0;
      uid_sh_q <= '{default: '0};
      cmd_q    <= '0;
      uid_q    <= '0;
      len_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      chk_q    <= chk_d;
      cmd_sh_q <= cmd_sh_d;
      len_sh_q <= len_sh_d;
      idx_q    <= idx_d;
      uid_sh_q <= uid_sh_d;
      cmd_q    <= cmd_d;
      uid_q    <= uid_d;
      len_q    <= len_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign bus.cmd_out     = cmd_q;
  assign bus.uid_out     = uid_q;
  assign bus.uid_len     = len_q;
  assign bus.frame_valid = valid_q;
  assign bus.err_pulse   = err_q;
  assign bus.err_code    = code_q;

endmodule
